// File: rtl/mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mode_ctrl_if
// Description : Button / mode-select signal bundle between a button source and
//               mode_ctrl. The mode_chg member exists only with MODE_CHG_PULSE_EN.
// Revision    : 1.0  initial release
// ============================================================================
interface mode_ctrl_if;
    logic btn;
    logic sel;
    logic btn_db;
`ifdef MODE_CHG_PULSE_EN
    logic mode_chg;

    modport master (output btn, input sel, input btn_db, input mode_chg);
    modport slave  (input btn, output sel, output btn_db, output mode_chg);
`else
    modport master (output btn, input sel, input btn_db);
    modport slave  (input btn, output sel, output btn_db);
`endif
endinterface
`default_nettype wire

// File: rtl/mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mode_ctrl
// Description : Debounces a raw mode button and toggles the up/down counter
//               direction once per accepted press. Optional macro
//               MODE_CHG_PULSE_EN adds the single-cycle mode_chg pulse.
// Revision    : 1.0  initial release
// ============================================================================
module mode_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter bit          SEL_RST    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    mode_ctrl_if.slave bus
);

    localparam logic [1:0] c_released  = 2'd0;
    localparam logic [1:0] c_pressing  = 2'd1;
    localparam logic [1:0] c_pressed   = 2'd2;
    localparam logic [1:0] c_releasing = 2'd3;
    localparam logic [7:0] c_deb       = 8'(DEB_CYCLES);

    logic       r_s1;
    logic       r_s2;
    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic       r_sel;
    logic       r_btn_db;

    logic [1:0] w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_press_acc;
    logic       w_sel_nxt;
    logic       w_btn_db_nxt;

    // btn is asynchronous; nothing but r_s1 may sample it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= bus.btn;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_released;
            r_cnt    <= 8'd0;
            r_sel    <= SEL_RST;
            r_btn_db <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_btn_db <= w_btn_db_nxt;
        end
    end

    // Counter stops at c_deb (at most 255), so it can never wrap
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_released: begin
                if (r_s2) begin
                    w_state_nxt = c_pressing;
                    w_cnt_nxt   = 8'd1;
                end
            end
            c_pressing: begin
                if (!r_s2) begin
                    w_state_nxt = c_released;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == c_deb) begin
                    w_state_nxt = c_pressed;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_pressed: begin
                if (!r_s2) begin
                    w_state_nxt = c_releasing;
                    w_cnt_nxt   = 8'd1;
                end
            end
            c_releasing: begin
                if (r_s2) begin
                    w_state_nxt = c_pressed;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == c_deb) begin
                    w_state_nxt = c_released;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_released;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it
    always_comb begin
        w_press_acc  = (r_state == c_pressing) && (w_state_nxt == c_pressed);
        w_sel_nxt    = w_press_acc ? ~r_sel : r_sel;
        w_btn_db_nxt = (w_state_nxt == c_pressed) || (w_state_nxt == c_releasing);
    end

    assign bus.sel    = r_sel;
    assign bus.btn_db = r_btn_db;

`ifdef MODE_CHG_PULSE_EN
    logic r_mode_chg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode_chg <= 1'b0;
        end else begin
            r_mode_chg <= w_press_acc;
        end
    end

    assign bus.mode_chg = r_mode_chg;
`endif

endmodule
`default_nettype wire
